regfile_wr_scoreboard: RTL and testbench
========================================

// Module: regfile_wr_scoreboard
// PURPOSE
// Parametrised successor to the 5:32 register-file write decoder. Registers a one-hot write
// enable for each of NUM_WR_PORTS writeback ports. Also keeps a pending-write scoreboard:
// the issue stage uses it to stall on write-after-write hazards. Sits between decode/issue,
// writeback and the register-file array in the pipelined CPU.
// PARAMETERS
// NUM_REGS      32   number of architectural registers (power of two, >= 4)
// ADDR_W        $clog2(NUM_REGS)  register address width (derived, do not override)
// NUM_WR_PORTS  2    writeback ports (1..4)
// ZERO_REG      31   hardwired-zero register index (XZR); never written, never pending
// PORTS
// clk            in   1                    single clock, all state on rising edge
// reset          in   1                    asynchronous, active-low; low clears all state
// issue_valid    in   1                    issue stage requests a new destination
// issue_reg      in   ADDR_W               destination register of issuing instruction
// issue_ready    out  1                    issue accepted this cycle (combinational)
// wb_valid       in   NUM_WR_PORTS         per-port writeback valid
// wb_reg         in   NUM_WR_PORTS*ADDR_W  per-port writeback address, port p at [p*ADDR_W +: ADDR_W]
// wr_en          out  NUM_REGS             registered one-hot(ish) register-file write enables
// pending        out  NUM_REGS             registered scoreboard, bit r = write to r outstanding
// pend_count     out  ADDR_W+1             registered count of set pending bits
// wr_conflict    out  1                    only with REGFILE_WR_CONFLICT_CHK_EN, else absent
// BEHAVIOUR
// - Reset (reset==0, async): wr_en=0, pending=0, pend_count=0, wr_conflict=0.
//   issue_ready therefore reads 1 during and after reset.
//   Any in-flight wr_en pulse is dropped; the next edge after release behaves as a cold start.
// - issue_ready = !pending[issue_reg], no writeback bypass.
//   issue_reg==ZERO_REG or issue_reg>=NUM_REGS always gives ready=1.
// - Accept = issue_valid & issue_ready. On accept, pending[issue_reg] sets at the next edge.
//   Exception: ZERO_REG and out-of-range indices are never set.
// - Writeback: for each p with wb_valid[p], wr_en[wb_reg[p]]=1 for exactly the next cycle
//   (latency 1). Enables from all ports are ORed. ZERO_REG and out-of-range addresses produce
//   no enable. No valid port gives wr_en all-zero.
// - Same cycle, pending[wb_reg[p]] clears at the next edge for each valid p.
// - Simultaneous set and clear of the same register in one cycle: set wins, bit stays 1.
//   This happens on a writeback to a non-pending register while issue targets it.
// - Writeback to a non-pending register: wr_en still pulses; no scoreboard change, no error.
// - Two ports, same address, same cycle: a single wr_en bit; clears pending once.
// - pend_count = popcount of the next-state pending vector, registered with pending.
//   It never exceeds NUM_REGS-1, because ZERO_REG is excluded.
// - No state machine beyond the scoreboard. All outputs except issue_ready are flop outputs.
// CONFIGURATION
// REGFILE_WR_CONFLICT_CHK_EN defined:
//   wr_conflict=1 for one cycle, aligned with wr_en, when two or more valid ports target the
//   same non-ZERO_REG in-range address. wr_en and pending behave exactly as without the macro.
// Undefined: the wr_conflict port and its logic are not present.
// TESTING
// 1 reset low mid-run with pending=0x0000_00F0 and wb_valid=1 -> pending, wr_en, pend_count
//   go 0 immediately without a clock; issue_ready=1.
// 2 issue reg 5, then wb port0 reg 5 two cycles later -> pending[5] 1 for 2 cycles;
//   wr_en=0x0000_0020 one cycle after wb; pend_count 1 then 0.
// 3 issue reg 5 while pending[5]=1 -> issue_ready=0 and no change.
//   issue reg 31 or wb reg 31 -> ready=1, no pending bit, wr_en=0.
// 4 wb port0 reg 3 and port1 reg 9 in the same cycle -> wr_en=0x0000_0208 next cycle;
//   both pending bits clear.
// 5 wb port0 reg 7 while issuing reg 7 (pending[7]=0) -> wr_en[7] pulses, pending[7]=1 next
//   cycle (set wins).
// 6 macro on, ports 0 and 1 both wb reg 12 -> wr_en=0x0000_1000, wr_conflict=1 for one cycle.
//   Same with reg 31 -> wr_conflict=0.

Source files
------------

// File: rtl/regfile_wr_scoreboard.sv
// Register-file write-enable decoder with a pending-write scoreboard for WAW stalls.
// Optional build macro REGFILE_WR_CONFLICT_CHK_EN adds the wr_conflict output.
module regfile_wr_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = $clog2(NUM_REGS),
    parameter int NUM_WR_PORTS = 2,
    parameter int ZERO_REG     = 31
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           issue_valid,
    input  logic [ADDR_W-1:0]              issue_reg,
    output logic                           issue_ready,
    input  logic [NUM_WR_PORTS-1:0]        wb_valid,
    input  logic [NUM_WR_PORTS*ADDR_W-1:0] wb_reg,
    output logic [NUM_REGS-1:0]            wr_en,
    output logic [NUM_REGS-1:0]            pending,
    output logic [ADDR_W:0]                pend_count
`ifdef REGFILE_WR_CONFLICT_CHK_EN
    ,
    output logic                           wr_conflict
`endif
);

    // The hardwired-zero register and out-of-range indices never enable or track a write.
    function automatic logic valid_addr(input logic [ADDR_W-1:0] a);
        return (int'(a) != ZERO_REG) && (int'(a) < NUM_REGS);
    endfunction

    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] pending_next;
    logic [ADDR_W:0]     count_next;
    logic                accept;
`ifdef REGFILE_WR_CONFLICT_CHK_EN
    logic                conflict_next;
`endif

    // No writeback bypass: a register retiring this cycle still stalls its issuer.
    assign issue_ready = !valid_addr(issue_reg) || !pending[issue_reg];
    assign accept      = issue_valid && issue_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        wb_hit     = '0;
        set_vec    = '0;
        count_next = '0;
`ifdef REGFILE_WR_CONFLICT_CHK_EN
        conflict_next = 1'b0;
`endif
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (wb_valid[p] && valid_addr(wb_reg[p*ADDR_W +: ADDR_W])) begin
`ifdef REGFILE_WR_CONFLICT_CHK_EN
                if (wb_hit[wb_reg[p*ADDR_W +: ADDR_W]])
                    conflict_next = 1'b1;
`endif
                wb_hit[wb_reg[p*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (accept && valid_addr(issue_reg))
            set_vec[issue_reg] = 1'b1;
        // Set is applied after clear so a same-cycle issue to a retiring register wins.
        pending_next = (pending & ~wb_hit) | set_vec;
        for (int r = 0; r < NUM_REGS; r++)
            count_next = count_next + (ADDR_W+1)'(pending_next[r]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en      <= '0;
            pending    <= '0;
            pend_count <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            wr_en      <= wb_hit;
            pending    <= pending_next;
            pend_count <= count_next;
        end
    end

`ifdef REGFILE_WR_CONFLICT_CHK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wr_conflict <= 1'b0;
        else
            wr_conflict <= conflict_next;
    end
`endif

endmodule

// File: tb/tb_regfile_wr_scoreboard.sv
// Directed bench for regfile_wr_scoreboard with hand-computed expectations.
// Define REGFILE_WR_CONFLICT_CHK_EN to also exercise wr_conflict.
module tb_regfile_wr_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_WR   = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     issue_valid;
    logic [ADDR_W-1:0]        issue_reg;
    logic                     issue_ready;
    logic [NUM_WR-1:0]        wb_valid;
    logic [NUM_WR*ADDR_W-1:0] wb_reg;
    logic [NUM_REGS-1:0]      wr_en;
    logic [NUM_REGS-1:0]      pending;
    logic [ADDR_W:0]          pend_count;
`ifdef REGFILE_WR_CONFLICT_CHK_EN
    logic                     wr_conflict;
`endif

    int checks = 0;
    int errors = 0;

    regfile_wr_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wr_en       (wr_en),
        .pending     (pending),
        .pend_count  (pend_count)
`ifdef REGFILE_WR_CONFLICT_CHK_EN
        ,
        .wr_conflict (wr_conflict)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_reg   = '0;
        wb_valid    = '0;
        wb_reg      = '0;
    endtask

    task automatic issue_one(input logic [ADDR_W-1:0] r);
        idle();
        issue_valid = 1'b1;
        issue_reg   = r;
        tick();
        idle();
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        issue_reg = 5'd5;
        reset     = 1'b0;
        #2;
        check("reset_pending", pending, 0);
        check("reset_wr_en", wr_en, 0);
        check("reset_count", pend_count, 0);
        check("reset_ready", issue_ready, 1);
        tick();
        reset = 1'b1;
        tick();

        // Issue reg 5, idle one cycle, then writeback on port 0.
        idle();
        issue_valid = 1'b1;
        issue_reg   = 5'd5;
        #1;
        check("t2_ready", issue_ready, 1);
        tick();
        idle();
        check("t2_pend_c1", pending, 32'h0000_0020);
        check("t2_count_c1", pend_count, 1);
        tick();
        check("t2_pend_c2", pending, 32'h0000_0020);
        wb_valid = 2'b01;
        wb_reg   = {5'd0, 5'd5};
        tick();
        idle();
        check("t2_wr_en", wr_en, 32'h0000_0020);
        check("t2_pend_clr", pending, 0);
        check("t2_count_clr", pend_count, 0);
        tick();
        check("t2_wr_en_drop", wr_en, 0);

        // WAW stall on reg 5, and the zero register is ignored.
        issue_one(5'd5);
        issue_valid = 1'b1;
        issue_reg   = 5'd5;
        #1;
        check("t3_stall", issue_ready, 0);
        tick();
        check("t3_stall_pend", pending, 32'h0000_0020);
        check("t3_stall_count", pend_count, 1);
        issue_reg = 5'd31;
        #1;
        check("t3_zero_ready", issue_ready, 1);
        tick();
        idle();
        check("t3_zero_pend", pending, 32'h0000_0020);
        wb_valid = 2'b01;
        wb_reg   = {5'd0, 5'd31};
        tick();
        idle();
        check("t3_zero_wr_en", wr_en, 0);
        check("t3_zero_wb_pend", pending, 32'h0000_0020);
        wb_valid = 2'b01;
        wb_reg   = {5'd0, 5'd5};
        tick();
        idle();
        check("t3_cleanup", pending, 0);

        // Dual-port writeback to distinct registers.
        issue_one(5'd3);
        issue_one(5'd9);
        check("t4_pend", pending, 32'h0000_0208);
        check("t4_count", pend_count, 2);
        wb_valid = 2'b11;
        wb_reg   = {5'd9, 5'd3};
        tick();
        idle();
        check("t4_wr_en", wr_en, 32'h0000_0208);
        check("t4_pend_clr", pending, 0);
        check("t4_count_clr", pend_count, 0);
`ifdef REGFILE_WR_CONFLICT_CHK_EN
        check("t4_no_conflict", wr_conflict, 0);
`endif

        // Set wins when issue and writeback hit a non-pending register together.
        issue_valid = 1'b1;
        issue_reg   = 5'd7;
        wb_valid    = 2'b01;
        wb_reg      = {5'd0, 5'd7};
        tick();
        idle();
        check("t5_wr_en", wr_en, 32'h0000_0080);
        check("t5_pend", pending, 32'h0000_0080);
        check("t5_count", pend_count, 1);
        wb_valid = 2'b01;
        wb_reg   = {5'd0, 5'd7};
        tick();
        idle();
        check("t5_cleanup", pending, 0);

        // Both ports retire reg 12: one enable bit, one clear.
        issue_one(5'd12);
        wb_valid = 2'b11;
        wb_reg   = {5'd12, 5'd12};
        tick();
        idle();
        check("t6_wr_en", wr_en, 32'h0000_1000);
        check("t6_pend", pending, 0);
        check("t6_count", pend_count, 0);
`ifdef REGFILE_WR_CONFLICT_CHK_EN
        check("t6_conflict", wr_conflict, 1);
`endif
        tick();
        check("t6_wr_en_drop", wr_en, 0);
`ifdef REGFILE_WR_CONFLICT_CHK_EN
        check("t6_conflict_drop", wr_conflict, 0);
`endif
        wb_valid = 2'b11;
        wb_reg   = {5'd31, 5'd31};
        tick();
        idle();
        check("t6_zero_wr_en", wr_en, 0);
`ifdef REGFILE_WR_CONFLICT_CHK_EN
        check("t6_zero_conflict", wr_conflict, 0);
`endif

        // Mid-run asynchronous reset with pending=0xF0 and an enable in flight.
        issue_one(5'd4);
        issue_one(5'd5);
        issue_one(5'd6);
        issue_one(5'd7);
        check("t1_pend_pre", pending, 32'h0000_00F0);
        check("t1_count_pre", pend_count, 4);
        wb_valid = 2'b01;
        wb_reg   = {5'd0, 5'd2};
        tick();
        check("t1_wr_en_pre", wr_en, 32'h0000_0004);
        issue_reg = 5'd5;
        #2;
        reset = 1'b0;
        #1;
        check("t1_pend_async", pending, 0);
        check("t1_wr_en_async", wr_en, 0);
        check("t1_count_async", pend_count, 0);
        check("t1_ready_async", issue_ready, 1);
        tick();
        check("t1_wr_en_held", wr_en, 0);
        #2;
        reset = 1'b1;
        idle();
        tick();
        check("t1_cold_wr_en", wr_en, 0);
        check("t1_cold_pend", pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
